// File: rtl/ncu_mcu_dn_pkg.sv
// ncu_mcu_dn_pkg
// Shared types for the NCU->MCU downstream packet scheduler.
//   dn_state_e       scheduler FSM state encoding
//   mcu_idx_t        2-bit destination MCU index
//   PKT_NIB_DEFAULT  default payload nibbles per packet
// Build option: NCU_MCU_DN_PARITY_EN adds the PAR state (parity nibble after payload).
package ncu_mcu_dn_pkg;

  localparam int PKT_NIB_DEFAULT = 16;

  typedef logic [1:0] mcu_idx_t;

`ifdef NCU_MCU_DN_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_PAR  = 2'd2,
    ST_GAP  = 2'd3
  } dn_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd3
  } dn_state_e;
`endif

endpackage

// File: rtl/ncu_mcu_dn_sched_rr_arb.sv
// ncu_mcu_dn_rr_arb
// Two-way round-robin arbiter for the downstream scheduler.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   eligible   per-requester eligibility (bit0 = req0, bit1 = req1)
//   advance    grant is being taken this cycle; pointer may move
//   grant      one-hot grant (or zero when nothing is eligible)
// The pointer selects the winner only under contention and after any grant
// it points at the requester that lost (or was not granted).
module ncu_mcu_dn_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr_q = 0 favours req0, 1 favours req1
  logic ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // granting req0 points at req1 and vice versa
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (grant != 2'b00)) ptr_d = grant[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ncu_mcu_dn_sched.sv
// ncu_mcu_dn_sched
// Schedules CSR (req0) and PIO (req1) packets onto four nibble-wide MCU links.
// A granted packet is latched and sent LSB nibble first on the chosen MCU,
// followed by one idle gap cycle.
// Ports:
//   iol2clk, rst                     clock, asynchronous active-high reset
//   reqN_vld/_mcu/_data, reqN_gnt    requester handshake (N = 0 CSR, 1 PIO)
//   ncu_mcuK_vld/_data               downstream nibble stream per MCU K
//   mcuK_ncu_stall                   MCU K cannot take a new packet
//   busy                             scheduler not in IDLE
// Build option: NCU_MCU_DN_PARITY_EN appends an XOR parity nibble (PAR state).
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | arbitrate eligible requesters; grant latches packet
// SEND    | drive one payload nibble per cycle to selected MCU
// PAR     | drive XOR of all payload nibbles (parity build only)
// GAP     | one cycle with all vld low, then back to IDLE
module ncu_mcu_dn_sched
  import ncu_mcu_dn_pkg::*;
#(
  parameter int PKT_NIB = PKT_NIB_DEFAULT
) (
  input  logic                 iol2clk,
  input  logic                 rst,
  input  logic                 req0_vld,
  input  logic [1:0]           req0_mcu,
  input  logic [4*PKT_NIB-1:0] req0_data,
  output logic                 req0_gnt,
  input  logic                 req1_vld,
  input  logic [1:0]           req1_mcu,
  input  logic [4*PKT_NIB-1:0] req1_data,
  output logic                 req1_gnt,
  output logic                 ncu_mcu0_vld,
  output logic [3:0]           ncu_mcu0_data,
  output logic                 ncu_mcu1_vld,
  output logic [3:0]           ncu_mcu1_data,
  output logic                 ncu_mcu2_vld,
  output logic [3:0]           ncu_mcu2_data,
  output logic                 ncu_mcu3_vld,
  output logic [3:0]           ncu_mcu3_data,
  input  logic                 mcu0_ncu_stall,
  input  logic                 mcu1_ncu_stall,
  input  logic                 mcu2_ncu_stall,
  input  logic                 mcu3_ncu_stall,
  output logic                 busy
);

  localparam int CW = $clog2(PKT_NIB + 1);
  localparam int PW = 4 * PKT_NIB;

  dn_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  mcu_idx_t          mcu_q, mcu_d;
  logic [PW-1:0]     pay_q, pay_d;
`ifdef NCU_MCU_DN_PARITY_EN
  logic [3:0]        par_q, par_d;
`endif

  logic [3:0] stall_v;
  logic [1:0] elig;
  logic [1:0] grant;
  logic       idle;
  logic       tx_vld;
  logic [3:0] tx_nib;
  logic [3:0] dn_vld;
  logic [3:0] dn_data [4];

  assign stall_v = {mcu3_ncu_stall, mcu2_ncu_stall, mcu1_ncu_stall, mcu0_ncu_stall};
  assign idle    = (state_q == ST_IDLE);

  // rst gating keeps gnt low while reset is held (FSM is already in IDLE then)
  assign elig[0] = idle & ~rst & req0_vld & ~stall_v[req0_mcu];
  assign elig[1] = idle & ~rst & req1_vld & ~stall_v[req1_mcu];

  ncu_mcu_dn_rr_arb u_arb (
    .clk      (iol2clk),
    .rst      (rst),
    .eligible (elig),
    .advance  (idle),
    .grant    (grant)
  );

  assign req0_gnt = grant[0];
  assign req1_gnt = grant[1];
  assign busy     = ~idle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcu_d   = mcu_q;
    pay_d   = pay_q;
`ifdef NCU_MCU_DN_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant[0]) begin
          mcu_d   = req0_mcu;
          pay_d   = req0_data;
          cnt_d   = CW'(PKT_NIB - 1);
          state_d = ST_SEND;
`ifdef NCU_MCU_DN_PARITY_EN
          par_d   = 4'h0;
`endif
        end else if (grant[1]) begin
          mcu_d   = req1_mcu;
          pay_d   = req1_data;
          cnt_d   = CW'(PKT_NIB - 1);
          state_d = ST_SEND;
`ifdef NCU_MCU_DN_PARITY_EN
          par_d   = 4'h0;
`endif
        end
      end
      ST_SEND: begin
        // payload shifts down so the current nibble is always pay_q[3:0]
        pay_d = pay_q >> 4;
`ifdef NCU_MCU_DN_PARITY_EN
        par_d = par_q ^ pay_q[3:0];
`endif
        if (cnt_q == '0) begin
`ifdef NCU_MCU_DN_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_GAP;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef NCU_MCU_DN_PARITY_EN
      ST_PAR:  state_d = ST_GAP;
`endif
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mcu_q   <= '0;
      pay_q   <= '0;
`ifdef NCU_MCU_DN_PARITY_EN
      par_q   <= 4'h0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcu_q   <= mcu_d;
      pay_q   <= pay_d;
`ifdef NCU_MCU_DN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // outputs decode from registered state only, so reset drops vld at once
  always_comb begin
    tx_vld = 1'b0;
    tx_nib = 4'h0;
    if (state_q == ST_SEND) begin
      tx_vld = 1'b1;
      tx_nib = pay_q[3:0];
    end
`ifdef NCU_MCU_DN_PARITY_EN
    if (state_q == ST_PAR) begin
      tx_vld = 1'b1;
      tx_nib = par_q;
    end
`endif
  end

  for (genvar k = 0; k < 4; k++) begin : g_dn
    assign dn_vld[k]  = tx_vld & (mcu_q == mcu_idx_t'(k));
    assign dn_data[k] = dn_vld[k] ? tx_nib : 4'h0;
  end

  assign ncu_mcu0_vld  = dn_vld[0];
  assign ncu_mcu1_vld  = dn_vld[1];
  assign ncu_mcu2_vld  = dn_vld[2];
  assign ncu_mcu3_vld  = dn_vld[3];
  assign ncu_mcu0_data = dn_data[0];
  assign ncu_mcu1_data = dn_data[1];
  assign ncu_mcu2_data = dn_data[2];
  assign ncu_mcu3_data = dn_data[3];

endmodule

// File: tb/tb_ncu_mcu_dn_sched.sv
module tb_ncu_mcu_dn_sched;

  logic        iol2clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_vld = 1'b0, req1_vld = 1'b0;
  logic [1:0]  req0_mcu = 2'd0, req1_mcu = 2'd0;
  logic [63:0] req0_data = '0, req1_data = '0;
  logic        req0_gnt, req1_gnt;
  logic        v0, v1, v2, v3;
  logic [3:0]  d0, d1, d2, d3;
  logic        s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 iol2clk = ~iol2clk;

  ncu_mcu_dn_sched #(.PKT_NIB(16)) dut (
    .iol2clk        (iol2clk),
    .rst            (rst),
    .req0_vld       (req0_vld),
    .req0_mcu       (req0_mcu),
    .req0_data      (req0_data),
    .req0_gnt       (req0_gnt),
    .req1_vld       (req1_vld),
    .req1_mcu       (req1_mcu),
    .req1_data      (req1_data),
    .req1_gnt       (req1_gnt),
    .ncu_mcu0_vld   (v0),
    .ncu_mcu0_data  (d0),
    .ncu_mcu1_vld   (v1),
    .ncu_mcu1_data  (d1),
    .ncu_mcu2_vld   (v2),
    .ncu_mcu2_data  (d2),
    .ncu_mcu3_vld   (v3),
    .ncu_mcu3_data  (d3),
    .mcu0_ncu_stall (s0),
    .mcu1_ncu_stall (s1),
    .mcu2_ncu_stall (s2),
    .mcu3_ncu_stall (s3),
    .busy           (busy)
  );

  wire [3:0]  vld_v = {v3, v2, v1, v0};
  wire [15:0] dat_v = {d3, d2, d1, d0};
  wire [1:0]  gnt_v = {req1_gnt, req0_gnt};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] place(input int k, input logic [3:0] n);
    place = 16'(n) << (4 * k);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  eg;
    logic [3:0]  nb;

    // reset state; a pending request must not be granted during reset
    req0_vld = 1'b1;
    @(negedge iol2clk);
    @(negedge iol2clk); #1;
    chk("rst_gnt",  gnt_v, 2'b00);
    chk("rst_vld",  vld_v, 4'b0000);
    chk("rst_data", dat_v, 16'h0);
    chk("rst_busy", busy, 1'b0);
    req0_vld = 1'b0;
    rst = 1'b0;

    // single packet req0 -> MCU2
    @(negedge iol2clk);
    req0_vld = 1'b1; req0_mcu = 2'd2; req0_data = 64'hFEDCBA9876543210;
    #1;
    chk("t1_gnt", gnt_v, 2'b01);
    @(posedge iol2clk); #1;
    req0_vld = 1'b0; req0_mcu = 2'd1; req0_data = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      @(negedge iol2clk); #1;
      nb = i[3:0];
      chk("t1_vld", vld_v, 4'b0100);
      chk("t1_nib", dat_v, place(2, nb));
    end
    @(negedge iol2clk); #1;
    chk("t1_gap_vld",  vld_v, 4'b0000);
    chk("t1_gap_busy", busy, 1'b1);
    @(negedge iol2clk); #1;
    chk("t1_idle_busy", busy, 1'b0);

    // contention after reset: pointer starts at req0, grants 18 cycles apart
    rst = 1'b1;
    @(negedge iol2clk);
    rst = 1'b0;
    for (int c = 0; c < 72; c++) begin
      @(negedge iol2clk);
      if (c == 0) begin
        req0_vld = 1'b1; req0_mcu = 2'd0; req0_data = 64'h1111_2222_3333_4444;
        req1_vld = 1'b1; req1_mcu = 2'd1; req1_data = 64'h5555_6666_7777_8888;
      end
      #1;
      if (c % 18 == 0) eg = ((c / 18) % 2 == 0) ? 2'b01 : 2'b10;
      else             eg = 2'b00;
      chk("t2_gnt", gnt_v, eg);
    end
    @(negedge iol2clk);
    req0_vld = 1'b0; req1_vld = 1'b0;
    #1;
    chk("t2_end_gnt",  gnt_v, 2'b00);
    chk("t2_end_busy", busy, 1'b0);

    // stall gating: req0 -> stalled MCU1 loses to req1 -> MCU3
    @(negedge iol2clk);
    s1 = 1'b1;
    req0_vld = 1'b1; req0_mcu = 2'd1; req0_data = 64'h0123456789ABCDEF;
    req1_vld = 1'b1; req1_mcu = 2'd3; req1_data = 64'h0;
    #1;
    chk("t3_gnt_first", gnt_v, 2'b10);
    @(posedge iol2clk); #1;
    req1_vld = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge iol2clk);
      if (c == 5) s1 = 1'b0;
      #1;
      chk("t3_gnt", gnt_v, (c == 18) ? 2'b01 : 2'b00);
      if (c <= 16)      chk("t3_vld", vld_v, 4'b1000);
      else if (c == 17) chk("t3_gap", vld_v, 4'b0000);
    end

    // mid-packet stall on active MCU1 must not interrupt the packet
    @(posedge iol2clk); #1;
    req0_vld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge iol2clk);
      if (i == 5) s1 = 1'b1;
      #1;
      nb = 4'(15 - i);
      chk("t4_vld", vld_v, 4'b0010);
      chk("t4_nib", dat_v, place(1, nb));
    end
    @(negedge iol2clk); #1;
    chk("t4_gap", vld_v, 4'b0000);
    s1 = 1'b0;

    // packet end: parity nibble (parity build) or gap straight after payload
    @(negedge iol2clk);
    req0_vld = 1'b1; req0_mcu = 2'd0; req0_data = 64'h0000000000000001;
    #1;
    chk("t5_gnt", gnt_v, 2'b01);
    @(posedge iol2clk); #1;
    req0_vld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge iol2clk); #1;
      chk("t5_nib", dat_v, place(0, (i == 0) ? 4'h1 : 4'h0));
    end
    @(negedge iol2clk); #1;
`ifdef NCU_MCU_DN_PARITY_EN
    chk("t5_par_vld", vld_v, 4'b0001);
    chk("t5_par_nib", dat_v, 16'h0001);
    @(negedge iol2clk); #1;
    chk("t5_gap_vld",  vld_v, 4'b0000);
    chk("t5_gap_busy", busy, 1'b1);
`else
    chk("t5_gap_vld",  vld_v, 4'b0000);
    chk("t5_gap_busy", busy, 1'b1);
    @(negedge iol2clk); #1;
    chk("t5_idle_busy", busy, 1'b0);
`endif

    // reset at nibble 7 truncates the packet for good
    @(negedge iol2clk);
    req1_vld = 1'b1; req1_mcu = 2'd0; req1_data = 64'hFEDCBA9876543210;
    #1;
    chk("t6_gnt", gnt_v, 2'b10);
    @(posedge iol2clk); #1;
    req1_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge iol2clk); #1;
      nb = i[3:0];
      chk("t6_nib", dat_v, place(0, nb));
    end
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_vld",  vld_v, 4'b0000);
    chk("t6_rst_busy", busy, 1'b0);
    @(negedge iol2clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge iol2clk); #1;
      chk("t6_post_vld", vld_v, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ncu_mcu_dn_sched.md
NCU_MCU_DN_SCHED -- requirements
Module: ncu_mcu_dn_sched

Interface
- REQ-001 SHALL have parameter PKT_NIB, default 16: payload nibbles per packet; payload width is 4*PKT_NIB bits.
- REQ-002 SHALL have port iol2clk, input, 1: sole clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
- REQ-004 SHALL have ports req0_vld / req1_vld, input, 1 each: requester has a packet pending (req0 = CSR path, req1 = PIO path).
- REQ-005 SHALL have ports req0_mcu / req1_mcu, input, 2 each: destination MCU index 0..3.
- REQ-006 SHALL have ports req0_data / req1_data, input, 4*PKT_NIB each: packet payload.
- REQ-007 SHALL have ports req0_gnt / req1_gnt, output, 1 each: one-cycle acceptance pulse; the payload is captured that cycle.
- REQ-008 SHALL have ports ncu_mcu0_vld..ncu_mcu3_vld, output, 1 each: downstream nibble valid per MCU.
- REQ-009 SHALL have ports ncu_mcu0_data..ncu_mcu3_data, output, 4 each: downstream nibble per MCU.
- REQ-010 SHALL have ports mcu0_ncu_stall..mcu3_ncu_stall, input, 1 each: MCU cannot accept a new packet.
- REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
- REQ-012 SHALL implement FSM states IDLE, SEND, PAR, GAP.
- REQ-013 In IDLE, requester N SHALL be eligible iff reqN_vld=1 and mcuK_ncu_stall=0, where K=reqN_mcu.
- REQ-014 If exactly one requester is eligible, it SHALL be granted; if both, the one indicated by the round-robin pointer wins.
- REQ-015 The round-robin pointer SHALL point to the non-granted requester after every grant and SHALL NOT change without a grant.
- REQ-016 On grant: gnt pulses for one cycle; payload and MCU index are latched; FSM goes IDLE->SEND.
- REQ-017 In SEND, the selected MCU's vld SHALL be 1 and its data SHALL carry latched nibbles LSB-first, one per cycle, for exactly PKT_NIB cycles.
- REQ-018 Latency SHALL be: grant at cycle t, nibble 0 at t+1, last nibble at t+PKT_NIB.
- REQ-019 After the last nibble: FSM SHALL go SEND->PAR if the parity feature is compiled in, otherwise SEND->GAP.
- REQ-020 GAP SHALL last exactly one cycle with every vld=0, then return to IDLE; earliest next grant is t+PKT_NIB+2 (without parity).
- REQ-021 Non-selected MCUs SHALL hold vld=0 and data=0; the selected MCU's data SHALL be 0 whenever its vld=0.
- REQ-022 Stall SHALL be sampled only in IDLE; stall asserted mid-packet SHALL NOT interrupt the packet.
- REQ-023 Changes to req inputs after grant SHALL NOT affect the packet in flight.
- REQ-024 The nibble counter SHALL be clog2(PKT_NIB+1) bits wide and SHALL NOT wrap within a packet.

Reset
- REQ-025 While rst=1: FSM=IDLE, pointer=req0, counter=0, all vld/data/gnt=0, busy=0.
- REQ-026 Reset during SEND or PAR SHALL force all vld low asynchronously; the truncated packet SHALL NOT be resumed after reset.

Configuration
- REQ-027 With NCU_MCU_DN_PARITY_EN defined: PAR lasts one cycle, vld=1, data = XOR of all PKT_NIB payload nibbles; GAP follows.
- REQ-028 Without NCU_MCU_DN_PARITY_EN: the PAR state and XOR logic SHALL be absent; SEND->GAP directly.

Structure
- REQ-029 Package ncu_mcu_dn_pkg SHALL hold the FSM state enum, the 2-bit MCU index typedef, and the default PKT_NIB constant.
- REQ-030 The 2-way round-robin arbiter SHALL be the sub-module ncu_mcu_dn_rr_arb: eligible[1:0] and advance in, grant[1:0] out.

Verification
- REQ-031 Single packet: req0_vld=1, req0_mcu=2, req0_data=0xFEDCBA9876543210 -> req0_gnt at t; ncu_mcu2_data=0,1,...,F over t+1..t+16; other MCUs' vld stay 0.
- REQ-032 Contention: both vld=1 every cycle, distinct MCUs, pointer=0 -> grants alternate req0,req1,req0,... spaced 18 cycles apart.
- REQ-033 Stall gating: mcu1_ncu_stall=1, req0->MCU1, req1->MCU3 -> req1 granted first; req0 granted in the first IDLE after stall drops.
- REQ-034 Mid-packet stall: assert stall on the active MCU at nibble 5 -> all 16 nibbles still sent, no gap in vld.
- REQ-035 Reset at nibble 7 -> vld=0 immediately; after release, no further nibbles until a new grant.
- REQ-036 Parity build, data=0x0000000000000001, PKT_NIB=16 -> PAR nibble = 0x1 at t+17; GAP at t+18.
